// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - single-cycle ALU with registered result plus iterative RV32M mul/div
// Iterative mul/div (ops 10-17) is compiled only when ALU_MULDIV_EN is defined.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] C,
    output logic             busy
);
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] quick_res;
    logic             accept;
    logic             is_iter;

    assign shamt  = B[SHW-1:0];
    assign accept = in_valid && in_ready && !flush;

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state, state_nx;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   hi, lo, opb;
    logic [4:0]         op_q;
    logic               neg_q;
    logic               div_zero, div_ovf, is_mul, is_div, sa, sb, last, done_take;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   div_sel, done_res;

    assign div_zero = (B == '0);
    assign div_ovf  = (A == MIN) && (B == ONES);
    assign is_mul   = (alu_op >= 5'd10) && (alu_op <= 5'd13);
    assign is_div   = (alu_op >= 5'd14) && (alu_op <= 5'd17);
    // Divide-by-zero and signed overflow (div/rem are the even codes) bypass the FSM.
    assign is_iter  = is_mul || (is_div && !div_zero && !(div_ovf && !alu_op[0]));
    assign sa = A[WIDTH-1] && (alu_op == 5'd11 || alu_op == 5'd12 || alu_op == 5'd14 || alu_op == 5'd16);
    assign sb = B[WIDTH-1] && (alu_op == 5'd11 || alu_op == 5'd14 || alu_op == 5'd16);
    assign last = (cnt == SHW'(WIDTH - 1));
`else
    assign is_iter  = 1'b0;
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    always_comb begin
        quick_res = '0;
        case (alu_op)
            5'd0:    quick_res = A + B;
            5'd1:    quick_res = A << shamt;
            5'd2:    quick_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            5'd3:    quick_res = {{(WIDTH-1){1'b0}}, A < B};
            5'd4:    quick_res = A ^ B;
            5'd5:    quick_res = A >> shamt;
            5'd6:    quick_res = $unsigned($signed(A) >>> shamt);
            5'd7:    quick_res = A | B;
            5'd8:    quick_res = A & B;
            5'd9:    quick_res = A - B;
`ifdef ALU_MULDIV_EN
            // Only the divide special cases consume these.
            5'd14:   quick_res = div_zero ? ONES : A;
            5'd15:   quick_res = ONES;
            5'd16:   quick_res = div_zero ? A : '0;
            5'd17:   quick_res = A;
`endif
            default: quick_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:     if (in_valid && is_iter) state_nx = is_mul ? MUL : DIV;
                MUL, DIV: if (last) state_nx = DONE;
                DONE:     state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        done_take = (state == DONE) && !flush;
    end

    // hi/lo double as accumulator/multiplier for MUL and remainder/quotient for DIV.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (accept && is_iter) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= sa ? -A : A;
            opb   <= sb ? -B : B;
            op_q  <= alu_op;
            neg_q <= (alu_op == 5'd16 || alu_op == 5'd17) ? sa : (sa ^ sb);
        end else if (state == MUL) begin
            cnt <= cnt + 1'b1;
            hi  <= mul_sum[WIDTH:1];
            lo  <= {mul_sum[0], lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            cnt <= cnt + 1'b1;
            if (!div_diff[WIDTH]) begin
                hi <= div_diff[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi <= div_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign mul_full = neg_q ? -{hi, lo} : {hi, lo};
    assign div_sel  = (op_q == 5'd14 || op_q == 5'd15) ? lo : hi;

    always_comb begin
        done_res = neg_q ? -div_sel : div_sel;
        if (op_q == 5'd10)      done_res = mul_full[WIDTH-1:0];
        else if (op_q <= 5'd13) done_res = mul_full[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            C         <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_iter) begin
                out_valid <= 1'b1;
                C         <= quick_res;
            end
`ifdef ALU_MULDIV_EN
            else if (done_take) begin
                out_valid <= 1'b1;
                C         <= done_res;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - randomized self-checking bench for alu_muldiv_unit
// Expectations follow ALU_MULDIV_EN exactly as the design build does.
module tb_alu_muldiv_unit;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [4:0]  op = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] res;
    int          checks = 0;
    int          errors = 0;
    bit          busy_seen = 1'b0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A(opa), .B(opb), .alu_op(op), .out_valid(out_valid), .C(res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (busy === 1'b1) busy_seen = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] v;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        v = '0;
        case (o)
            5'd0: return a + b;
            5'd1: return a << b[4:0];
            5'd2: return (sa < sb) ? 32'd1 : 32'd0;
            5'd3: return (ua < ub) ? 32'd1 : 32'd0;
            5'd4: return a ^ b;
            5'd5: return a >> b[4:0];
            5'd6: begin p = sa >>> b[4:0]; return p[31:0]; end
            5'd7: return a | b;
            5'd8: return a & b;
            5'd9: return a - b;
            5'd10: begin p = ua * ub; v = p[31:0]; end
            5'd11: begin p = sa * sb; v = p[63:32]; end
            5'd12: begin p = sa * ub; v = p[63:32]; end
            5'd13: begin p = ua * ub; v = p[63:32]; end
            5'd14: begin
                if (b == 0) v = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) v = a;
                else begin p = sa / sb; v = p[31:0]; end
            end
            5'd15: begin if (b == 0) v = '1; else begin p = ua / ub; v = p[31:0]; end end
            5'd16: begin if (b == 0) v = a; else begin p = sa % sb; v = p[31:0]; end end
            5'd17: begin if (b == 0) v = a; else begin p = ua % ub; v = p[31:0]; end end
            default: return 32'd0;
        endcase
        return MD ? v : 32'd0;
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        bit iter;
        iter = (o >= 5'd10 && o <= 5'd13) ||
               (o >= 5'd14 && o <= 5'd17 && b != 0 &&
                !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF && (o == 5'd14 || o == 5'd16)));
        return (MD && iter) ? W + 2 : 1;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            4: return 32'h0 - 32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rnd_basic_op();
        logic [4:0] o;
        o = 5'($urandom_range(0, 23));
        if (o >= 5'd10) o = o + 5'd8;
        return o;
    endfunction

    task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output int lat, output int bsy, output int nrdy);
        @(negedge clk);
        op = o; opa = a; opb = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1; bsy = 0; nrdy = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bsy++;
            if (in_ready !== 1'b1) nrdy++;
            @(posedge clk);
            #1;
            lat++;
        end
        c = res;
    endtask

    task automatic test_reset();
        logic [31:0] c;
        int lat, bsy, nrdy, seen;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || res !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b C=%h in_ready=%b busy=%b, want 0 0 1 0", out_valid, res, in_ready, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        do_op(5'd0, 32'd20, 32'd22, c, lat, bsy, nrdy);
        checks++;
        if (c !== 32'd42 || lat != 1) begin
            errors++;
            $display("FAIL reset_first_add: C=%h lat=%0d, want 0000002a lat=1", c, lat);
        end
        @(negedge clk);
        op = 5'd11; opa = 32'h1234_5678; opb = 32'h0000_0F0F; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || res !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream: out_valid=%b C=%h in_ready=%b busy=%b, want 0 0 1 0", out_valid, res, in_ready, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_discard: out_valid pulses=%0d, want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic [31:0] c, a, b;
        logic [4:0] o;
        int lat, bsy, nrdy;
        do_op(5'd9, 32'd5, 32'd7, c, lat, bsy, nrdy);
        checks++;
        if (c !== 32'hFFFF_FFFE || lat != 1) begin
            errors++;
            $display("FAIL sub_5_7: C=%h lat=%0d, want fffffffe lat=1", c, lat);
        end
        do_op(5'd6, 32'h8000_0000, 32'h21, c, lat, bsy, nrdy);
        checks++;
        if (c !== 32'hC000_0000 || lat != 1) begin
            errors++;
            $display("FAIL sra_wrap_shamt: C=%h lat=%0d, want c0000000 lat=1", c, lat);
        end
        for (int i = 0; i < 40; i++) begin
            o = rnd_basic_op(); a = rnd_val(); b = rnd_val();
            do_op(o, a, b, c, lat, bsy, nrdy);
            checks++;
            if (c !== model(o, a, b) || lat != 1 || bsy != 0) begin
                errors++;
                $display("FAIL basic_rand op=%0d A=%h B=%h: C=%h lat=%0d busy_cycles=%0d, want %h lat=1 busy_cycles=0",
                         o, a, b, c, lat, bsy, model(o, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin
                o = (i == 0) ? 5'd0 : (i == 1) ? 5'd3 : 5'd2;
                a = 32'hFFFF_FFFF; b = 32'd1;
            end else begin
                o = rnd_basic_op(); a = rnd_val(); b = rnd_val();
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            op = o; opa = a; opb = b; in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || res !== model(o, a, b)) begin
                errors++;
                $display("FAIL b2b_result[%0d] op=%0d: out_valid=%b C=%h, want 1 %h", i, o, out_valid, res, model(o, a, b));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_muldiv();
        logic [4:0]  t_op  [7] = '{5'd11, 5'd12, 5'd14, 5'd16, 5'd15, 5'd14, 5'd16};
        logic [31:0] t_a   [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [7] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        int          t_lat [7] = '{W + 2, W + 2, W + 2, W + 2, 1, 1, 1};
        logic [31:0] c, a, b;
        logic [4:0] o;
        int lat, bsy, nrdy;
`ifdef ALU_MULDIV_EN
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], c, lat, bsy, nrdy);
            checks++;
            if (c !== t_exp[i] || lat != t_lat[i] || nrdy != t_lat[i] - 1) begin
                errors++;
                $display("FAIL md_vec[%0d] op=%0d: C=%h lat=%0d not_ready=%0d, want %h lat=%0d not_ready=%0d",
                         i, t_op[i], c, lat, nrdy, t_exp[i], t_lat[i], t_lat[i] - 1);
            end
        end
`else
        do_op(5'd10, 32'd3, 32'd4, c, lat, bsy, nrdy);
        checks++;
        if (c !== 32'h0 || lat != 1) begin
            errors++;
            $display("FAIL md_off_mul: C=%h lat=%0d, want 00000000 lat=1", c, lat);
        end
`endif
        for (int i = 0; i < 30; i++) begin
            o = 5'($urandom_range(10, 17)); a = rnd_val(); b = rnd_val();
            do_op(o, a, b, c, lat, bsy, nrdy);
            checks++;
            if (c !== model(o, a, b) || lat != exp_lat(o, a, b) || bsy != lat - 1 || nrdy != lat - 1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL md_rand op=%0d A=%h B=%h: C=%h lat=%0d busy=%0d not_ready=%0d rdy_at_out=%b, want %h lat=%0d busy/not_ready=%0d rdy=1",
                         o, a, b, c, lat, bsy, nrdy, in_ready, model(o, a, b), exp_lat(o, a, b), exp_lat(o, a, b) - 1);
            end
        end
`ifndef ALU_MULDIV_EN
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL md_off_busy: busy asserted=%b, want 0", busy_seen);
        end
`endif
    endtask

    task automatic test_flush();
        logic [31:0] c, held;
        int lat, bsy, nrdy, seen;
`ifdef ALU_MULDIV_EN
        @(negedge clk);
        op = 5'd10; opa = $urandom; opb = $urandom; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_mid: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk) flush = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_mid_drop: out_valid pulses=%0d, want 0", seen);
        end
        held = res;
        @(negedge clk);
        op = 5'd13; opa = $urandom; opb = $urandom; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: busy=%b in_ready=%b out_valid=%b, want 1 0 0", busy, in_ready, out_valid);
        end
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || res !== held || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b C=%h in_ready=%b, want 0 %h 1", out_valid, res, in_ready, held);
        end
`endif
        do_op(5'd0, 32'd1, 32'd1, c, lat, bsy, nrdy);
        checks++;
        if (c !== 32'd2 || lat != 1) begin
            errors++;
            $display("FAIL post_flush_add: C=%h lat=%0d, want 00000002 lat=1", c, lat);
        end
        @(negedge clk);
        op = 5'd0; opa = 32'd5; opb = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (3) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0 || res !== 32'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_with_input: pulses=%0d C=%h in_ready=%b, want 0 00000002 1", seen, res, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_muldiv();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised successor to the single-cycle integer ALU. Keeps ALU ops 0-9 with a registered result and adds iterative RV32M multiply/divide ops. It sits in the Execute stage and signals stall through a valid/ready input handshake. Results leave as a one-cycle out_valid pulse with no output backpressure, so the pipeline must always accept them.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >=8)
SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  abort the in-flight op and drop any same-cycle input
in_valid  input  1  operands/op present
in_ready  output  1  unit can accept; handshake when in_valid && in_ready
A  input  WIDTH  operand A
B  input  WIDTH  operand B
alu_op  input  5  operation code
out_valid  output  1  C valid this cycle (single-cycle pulse)
C  output  WIDTH  result, held until next result
busy  output  1  iterative op in progress

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, C=0, in_ready=1, busy=0, FSM=IDLE.
  - Reset mid-operation discards the op with no output.
- Opcodes:
  - 0 add, 1 sll, 2 slt signed, 3 sltu, 4 xor, 5 srl, 6 sra (true arithmetic shift on signed A), 7 or, 8 and, 9 sub.
  - 10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu.
  - 18-31: result 0, latency 1.
- Width rules:
  - Shifts use B[SHW-1:0] only.
  - add/sub wrap modulo 2^WIDTH.
  - slt/sltu return 0 or 1, zero-extended.
- Basic ops (0-9, 18-31):
  - Accepted at edge k; C and out_valid=1 at edge k+1 (latency 1).
  - in_ready stays 1, so back-to-back issue gives one result per cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL (ops 10-13) or DIV (ops 14-17) on handshake. Operand signs are captured at accept.
  - MUL: radix-2 shift-add on magnitudes, WIDTH iterations, then sign fix. Low or high half is selected per op.
  - DIV: restoring division on magnitudes, WIDTH iterations, then sign fix. Quotient or remainder is selected per op.
  - Counter runs 0..WIDTH-1, then the FSM moves to DONE.
  - DONE: C and out_valid=1 are registered, then the FSM returns to IDLE.
  - Latency from accept edge to out_valid is WIDTH+2 cycles.
  - in_ready=0 and busy=1 from the cycle after accept until the DONE cycle, inclusive.
  - in_ready returns to 1 in the cycle out_valid is high, so the next op can issue in the same cycle.
- Division special cases (latency 1, no FSM entry):
  - Divide by zero: div/divu give all ones; rem/remu give A.
  - Signed overflow (A = -2^(WIDTH-1), B = -1): div gives A; rem gives 0.
- Flush:
  - Synchronous. FSM goes to IDLE and out_valid is forced 0 for the next edge.
  - C holds its old value and in_ready=1 the following cycle.
  - flush together with a handshake: flush wins and the input is dropped.
  - A flush on the same cycle as DONE suppresses that result.
- Handshake:
  - in_valid while in_ready=0 is ignored, not queued.
  - Upstream must hold its inputs until accepted.

Optional Feature:
ALU_MULDIV_EN
- Defined: ops 10-17 behave as above.
- Undefined: the FSM, multiplier and divider are not compiled. Ops 10-17 are treated as unassigned (C=0, latency 1). in_ready is tied to 1 and busy to 0.

Test Plan:
- Reset/basic ops, WIDTH=32: pulse rst_n low mid-stream -> all outputs 0 immediately. After release, issue op9 A=5 B=7 -> C=0xFFFFFFFE, out_valid 1 cycle later. Then op6 A=0x80000000 B=0x21 -> C=0xC0000000 (shift by 1).
- Back-to-back: ops 0,3,2 with A=0xFFFFFFFF, B=1 on consecutive cycles -> results 0x0, 0x0, 0x1 on 3 consecutive cycles, in_ready constantly 1.
- Multiply: op11 A=0x80000000 B=0x80000000 -> C=0x40000000 at exactly 34 cycles after accept, in_ready low for the intervening cycles. op12 A=-1 B=0xFFFFFFFF -> C=0xFFFFFFFF.
- Divide: op14 A=-7 B=2 -> C=0xFFFFFFFD; op16 -> 0xFFFFFFFF; op15 A=100 B=0 -> 0xFFFFFFFF at latency 1; op14 A=0x80000000 B=-1 -> 0x80000000; op16 same operands -> 0.
- Flush: start op10, assert flush at iteration 10 -> no out_valid, in_ready=1 next cycle, next op0 A=1 B=1 -> C=2. Flush together with in_valid -> nothing issued.
- Macro off: rebuild without ALU_MULDIV_EN, issue op10 A=3 B=4 -> C=0 after 1 cycle, busy never asserted.
